// File: rtl/sync_fifo_resp_if.sv
// Handshake bundle between the FIFO test driver (master) and the responder FIFO (slave).
interface sync_fifo_resp_if #(
  parameter int DW = 24,
  parameter int AW = 4
);
  logic          winc;
  logic [DW-1:0] wdata;
  logic [1:0]    wfull;
  logic          rinc;
  logic [DW-1:0] rdata;
  logic [1:0]    rempty;
  logic [AW:0]   count;
  logic          ovf;
  logic          udf;

  modport master (
    output winc, wdata, rinc,
    input  wfull, rdata, rempty, count, ovf, udf
  );

  modport slave (
    input  winc, wdata, rinc,
    output wfull, rdata, rempty, count, ovf, udf
  );
endinterface

// File: rtl/sync_fifo_resp.sv
// Single-clock first-word-fall-through FIFO with 2-bit full/empty status
// ({almost, exact}) and sticky overflow/underflow flags.
module sync_fifo_resp #(
  parameter int DW     = 24,
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int AF_GAP = 2,
  parameter int AE_GAP = 2
) (
  input logic              CLK,
  input logic              RST,
  sync_fifo_resp_if.slave  bus
);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_LVL   = (AW+1)'(DEPTH - AF_GAP);
  localparam logic [AW:0] AE_LVL   = (AW+1)'(AE_GAP);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          ovf, udf;
  logic          wr_ok, rd_ok;

  assign wr_ok = bus.winc && (count != FULL_LVL);
  assign rd_ok = bus.rinc && (count != '0);

  // NOTE: storage is deliberately left out of reset; the pointers define validity,
  // and a reset-free array maps onto plain register/RAM cells.
  always_ff @(posedge CLK) begin
    if (!RST && wr_ok) mem[wptr] <= bus.wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      unique case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (bus.winc && !wr_ok) ovf <= 1'b1;
      if (bus.rinc && !rd_ok) udf <= 1'b1;
    end
  end

  // Status is decoded straight from the registered count: no extra latency.
  always_comb begin
    bus.wfull  = 2'b00;
    bus.rempty = 2'b00;
    if (count == FULL_LVL)  bus.wfull = 2'b01;
    else if (count >= AF_LVL) bus.wfull = 2'b10;
    if (count == '0)        bus.rempty = 2'b01;
    else if (count <= AE_LVL) bus.rempty = 2'b10;
  end

  assign bus.rdata = mem[rptr];
  assign bus.count = count;
  assign bus.ovf   = ovf;
  assign bus.udf   = udf;
endmodule
